// File: rtl/tc_pl_cap_gain_dac_multi_set_if.sv
// rtl/tc_pl_cap_gain_dac_multi_set_if.sv - word stream between DAC sequencer and SPI master
interface tc_pl_cap_gain_dac_multi_set_if #(
    parameter int SPI_W = 8
);
    logic             stx_idle;
    logic             stx_dreq;
    logic             stx_valid;
    logic [SPI_W-1:0] stx_data;

    // sequencer side: offers words, observes SPI master readiness
    modport master (
        input  stx_idle,
        input  stx_dreq,
        output stx_valid,
        output stx_data
    );

    // SPI master side
    modport slave (
        output stx_idle,
        output stx_dreq,
        input  stx_valid,
        input  stx_data
    );
endinterface

// File: rtl/tc_pl_cap_gain_dac_multi_set.sv
// rtl/tc_pl_cap_gain_dac_multi_set.sv - multi-channel DAC word sequencer (optional load strobe: TC_DAC_LDAC_EN)
module tc_pl_cap_gain_dac_multi_set #(
    parameter int CH_NUM = 4,
    parameter int BYTES  = 3,
    parameter int SPI_W  = 8,
    parameter int LDAC_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CH_NUM*BYTES*SPI_W-1:0] dac_value,
    input  logic [CH_NUM-1:0]             ch_mask,
    input  logic                          msb_first,
    input  logic                          dac_en,
    output logic                          dac_cmpt,
    output logic                          busy,
    output logic [CH_NUM-1:0]             ch_sel,
    output logic                          ch_done,
`ifdef TC_DAC_LDAC_EN
    output logic                          ldac_n,
`endif
    tc_pl_cap_gain_dac_multi_set_if.master stx
);

    localparam int CW = $clog2(BYTES + 1);
    localparam int PW = $clog2(CH_NUM + 1);
    localparam int IW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int VW = (CH_NUM * BYTES * SPI_W > 1) ? $clog2(CH_NUM * BYTES * SPI_W) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_TXD  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
`ifdef TC_DAC_LDAC_EN
    localparam logic [2:0] S_LDAC = 3'd4;
`endif
    localparam logic [2:0] S_CMPT = 3'd5;

    logic [2:0]                    state_q, state_d;
    logic [CH_NUM*BYTES*SPI_W-1:0] val_q, val_d;
    logic [CH_NUM-1:0]             mask_q, mask_d;
    logic                          msb_q, msb_d;
    logic [PW-1:0]                 ptr_q, ptr_d;
    logic [IW-1:0]                 cur_q, cur_d;
    logic [CW-1:0]                 wcnt_q, wcnt_d;
    logic                          armed_q, armed_d;
    logic [CH_NUM-1:0]             sel_q, sel_d;
    logic                          valid_q, valid_d;
    logic [SPI_W-1:0]              data_q, data_d;
    logic                          done_q, done_d;
    logic                          cmpt_q, cmpt_d;
`ifdef TC_DAC_LDAC_EN
    logic [3:0]                    lcnt_q, lcnt_d;
    logic                          ldac_q, ldac_d;
`endif

    logic                          ld_found;
    logic [IW-1:0]                 ld_idx;
    logic [CH_NUM-1:0]             ld_sel;
    logic                          nx_found;

    // k-th word sent for channel ch, honouring the latched send order
    function automatic logic [SPI_W-1:0] word_at(input logic [IW-1:0] ch, input logic [CW-1:0] k);
        int w;
        w = msb_q ? (BYTES - 1 - int'(k)) : int'(k);
        return val_q[VW'((int'(ch) * BYTES + w) * SPI_W) +: SPI_W];
    endfunction

    // lowest enabled channel at/above the pointer, and whether any remain past the current one
    always_comb begin
        ld_found = 1'b0;
        ld_idx   = '0;
        nx_found = 1'b0;
        for (int c = CH_NUM - 1; c >= 0; c--) begin
            if (mask_q[c] && (PW'(c) >= ptr_q)) begin
                ld_found = 1'b1;
                ld_idx   = IW'(c);
            end
            if (mask_q[c] && (IW'(c) > cur_q)) begin
                nx_found = 1'b1;
            end
        end
        for (int c = 0; c < CH_NUM; c++) begin
            ld_sel[c] = (IW'(c) == ld_idx);
        end
    end

    // sequencer next-state: latch, per-channel word streaming, completion
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        mask_d  = mask_q;
        msb_d   = msb_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        wcnt_d  = wcnt_q;
        armed_d = armed_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        data_d  = data_q;
        done_d  = 1'b0;
        cmpt_d  = cmpt_q;
`ifdef TC_DAC_LDAC_EN
        lcnt_d  = lcnt_q;
        ldac_d  = ldac_q;
`endif
        if (!dac_en) begin
            // abort/clear; a word the SPI master already took is left alone
            state_d = S_IDLE;
            ptr_d   = '0;
            wcnt_d  = '0;
            armed_d = 1'b0;
            sel_d   = '0;
            valid_d = 1'b0;
            cmpt_d  = 1'b0;
`ifdef TC_DAC_LDAC_EN
            lcnt_d  = '0;
            ldac_d  = 1'b1;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    val_d  = dac_value;
                    mask_d = ch_mask;
                    msb_d  = msb_first;
                    ptr_d  = '0;
                    wcnt_d = '0;
                    if (ch_mask == '0) begin
                        state_d = S_CMPT;
                        cmpt_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (ld_found) begin
                        cur_d   = ld_idx;
                        sel_d   = ld_sel;
                        data_d  = word_at(ld_idx, '0);
                        valid_d = 1'b1;
                        wcnt_d  = '0;
                        state_d = S_TXD;
                    end else begin
                        state_d = S_CMPT;
                        cmpt_d  = 1'b1;
                    end
                end
                S_TXD: begin
                    if (valid_q && stx.stx_dreq) begin
                        wcnt_d = wcnt_q + 1'b1;
                        if (wcnt_q == CW'(BYTES - 1)) begin
                            valid_d = 1'b0;
                            armed_d = 1'b0;
                            state_d = S_WAIT;
                        end else begin
                            data_d = word_at(cur_q, wcnt_q + 1'b1);
                        end
                    end
                end
                S_WAIT: begin
                    // first cycle lets the SPI master drop idle for the last word
                    if (!armed_q) begin
                        armed_d = 1'b1;
                    end else if (stx.stx_idle) begin
                        armed_d = 1'b0;
                        done_d  = 1'b1;
                        sel_d   = '0;
                        ptr_d   = PW'(cur_q) + PW'(1);
                        if (nx_found) begin
                            state_d = S_LOAD;
                        end else begin
`ifdef TC_DAC_LDAC_EN
                            state_d = S_LDAC;
                            ldac_d  = 1'b0;
                            lcnt_d  = 4'd1;
`else
                            state_d = S_CMPT;
                            cmpt_d  = 1'b1;
`endif
                        end
                    end
                end
`ifdef TC_DAC_LDAC_EN
                S_LDAC: begin
                    if (lcnt_q == 4'(LDAC_W)) begin
                        ldac_d  = 1'b1;
                        state_d = S_CMPT;
                        cmpt_d  = 1'b1;
                    end else begin
                        lcnt_d = lcnt_q + 4'd1;
                    end
                end
`endif
                S_CMPT: begin
                    cmpt_d  = 1'b1;
                    valid_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            val_q   <= '0;
            mask_q  <= '0;
            msb_q   <= 1'b0;
            ptr_q   <= '0;
            cur_q   <= '0;
            wcnt_q  <= '0;
            armed_q <= 1'b0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            cmpt_q  <= 1'b0;
`ifdef TC_DAC_LDAC_EN
            lcnt_q  <= '0;
            ldac_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            mask_q  <= mask_d;
            msb_q   <= msb_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            wcnt_q  <= wcnt_d;
            armed_q <= armed_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            done_q  <= done_d;
            cmpt_q  <= cmpt_d;
`ifdef TC_DAC_LDAC_EN
            lcnt_q  <= lcnt_d;
            ldac_q  <= ldac_d;
`endif
        end
    end

    assign busy          = (state_q != S_IDLE) && (state_q != S_CMPT);
    assign dac_cmpt      = cmpt_q;
    assign ch_sel        = sel_q;
    assign ch_done       = done_q;
    assign stx.stx_valid = valid_q;
    assign stx.stx_data  = data_q;
`ifdef TC_DAC_LDAC_EN
    assign ldac_n        = ldac_q;
`endif

endmodule

// File: doc/tc_pl_cap_gain_dac_multi_set.md
TC_PL_CAP_GAIN_DAC_MULTI_SET -- requirements
Module: tc_pl_cap_gain_dac_multi_set

Interface
REQ-001 SHALL have parameter CH_NUM, default 4: number of DAC channels, 1..8.
REQ-002 SHALL have parameter BYTES, default 3: SPI words per channel, 1..4.
REQ-003 SHALL have parameter SPI_W, default 8: SPI word width.
REQ-004 SHALL have parameter LDAC_W, default 4: ldac_n low-pulse length in clk cycles, 1..15 (used only when TC_DAC_LDAC_EN is defined).
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset; synchronous, active-low.
REQ-007 dac_value  in  CH_NUM*BYTES*SPI_W  channel c occupies slice [c*BYTES*SPI_W +: BYTES*SPI_W]; word k of channel c is [(c*BYTES+k)*SPI_W +: SPI_W].
REQ-008 ch_mask  in  CH_NUM  1 = channel is written in this sequence.
REQ-009 msb_first  in  1  0 = word 0 sent first; 1 = word BYTES-1 sent first.
REQ-010 dac_en  in  1  level request; high starts a sequence, low aborts or clears it.
REQ-011 dac_cmpt  out  1  sequence complete, held while dac_en is high.
REQ-012 busy  out  1  high in every state except S_IDLE and S_CMPT.
REQ-013 ch_sel  out  CH_NUM  one-hot chip select of the channel being written; all zero otherwise.
REQ-014 ch_done  out  1  one-cycle pulse per completed channel.
REQ-015 stx_idle / stx_dreq  in  1 / 1  SPI master idle / word accept.
REQ-016 stx_valid / stx_data  out  1 / SPI_W  word to SPI master.
REQ-017 ldac_n  out  1  DAC load strobe, active-low; present only when TC_DAC_LDAC_EN is defined.

Function
REQ-018 States: S_IDLE, S_LOAD, S_TXD, S_WAIT, S_LDAC, S_CMPT; all registered.
REQ-019 S_IDLE with dac_en=1: latch dac_value, ch_mask and msb_first; channel pointer to 0; go to S_LOAD. If ch_mask=0, go directly to S_CMPT.
REQ-020 Input changes after the latch have no effect until the next S_IDLE exit.
REQ-021 S_LOAD: select the lowest-index enabled channel at or above the pointer; drive ch_sel one-hot; load the first word into stx_data; set stx_valid=1; go to S_TXD. stx_valid rises 2 cycles after dac_en is first sampled high.
REQ-022 S_TXD: a word transfers on a cycle with stx_valid and stx_dreq both high. On that edge, stx_data loads the next word in the selected order. The transfer of the final (BYTES-th) word clears stx_valid and moves to S_WAIT.
REQ-023 stx_data SHALL hold its value while stx_valid=1 and stx_dreq=0.
REQ-024 S_WAIT: stx_idle is sampled from the second cycle in the state. When stx_idle=1: pulse ch_done, clear ch_sel, set the pointer to the channel index plus 1. Then go to S_LOAD if any enabled channel remains; otherwise go to S_LDAC (macro defined) or S_CMPT.
REQ-025 S_CMPT: dac_cmpt=1 and stx_valid=0; remain here until dac_en=0.
REQ-026 dac_en=0 in any state: next edge goes to S_IDLE and clears stx_valid, dac_cmpt, ch_sel, ch_done, the word counter and the pointer. A word already accepted by the SPI master is not recalled.
REQ-027 The word counter is ceil(log2(BYTES+1)) bits wide. The channel pointer wraps to 0 only through S_IDLE; it never wraps mid-sequence.
REQ-028 stx_dreq while stx_valid=0 SHALL be ignored.

Reset
REQ-029 rst=0 at a clock edge: state goes to S_IDLE; dac_cmpt, busy, ch_done, stx_valid, ch_sel and stx_data go to 0; ldac_n goes to 1; all counters clear.
REQ-030 Reset SHALL take priority over dac_en.

Configuration
REQ-031 Macro TC_DAC_LDAC_EN defined: S_LDAC drives ldac_n=0 for exactly LDAC_W cycles, then ldac_n=1 and the state moves to S_CMPT, so dac_cmpt rises LDAC_W cycles after the last ch_done.
REQ-032 Macro TC_DAC_LDAC_EN undefined: S_LDAC and the ldac_n port are absent, and the state moves from S_WAIT directly to S_CMPT.

Verification
REQ-033 Defaults; ch_mask=4'b0101; msb_first=0; stx_dreq always 1; channel 0 = 0x123456 -> words 0x56,0x34,0x12 with ch_sel=0001, then channel 2 words with ch_sel=0100; 2 ch_done pulses; dac_cmpt high.
REQ-034 msb_first=1; ch_mask=4'b1000; channel 3 = 0xA1B2C3 -> words 0xA1,0xB2,0xC3.
REQ-035 stx_dreq high only every 5th cycle -> stx_data stable between accepts; exactly 3 accepts per channel.
REQ-036 ch_mask=0 -> dac_cmpt high 1 cycle after dac_en, stx_valid never high.
REQ-037 dac_en dropped after the 2nd word -> next cycle stx_valid=0, ch_sel=0, busy=0; re-raising dac_en restarts from channel 0, word 0.
REQ-038 TC_DAC_LDAC_EN defined, LDAC_W=4 -> ldac_n low for exactly 4 cycles after the last ch_done, dac_cmpt on the following edge; rst=0 mid-pulse -> ldac_n=1 next cycle.
